// File: rtl/dvi_in_align_ctrl.sv
// dvi_in_align_ctrl: link-alignment sequencer for the three TMDS deserialiser
// pipelines (ch0=blue, ch1=green, ch2=red). It sweeps the input delay taps of
// each channel, scores every tap with the pipeline quality metric, applies the
// chosen tap, then bitslips until the channel reports valid symbols.
// Optional build macro: DVI_IN_ALIGN_WINDOW_EN. When defined, the tap is the
// centre of the longest run of passing taps instead of the arg-max tap.
//
// Handshake: start_i and abort_i are single-cycle pulses sampled on clk_i with
// no ready. start_i is accepted only while idle or done (dropped while busy_o),
// abort_i is accepted in every state and wins over a coincident start_i.
// The FSM state is held in state_q (type state_e) for checker binding.
module dvi_in_align_ctrl #(
  parameter int DelayW       = 5,
  parameter int QualityW     = 8,
  parameter int SettleCycles = 16,
  parameter int DwellCycles  = 1024,
  parameter int MaxSlips     = 10,
  parameter int MinQuality   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [2:0]            valid_i,
  input  logic [3*QualityW-1:0] quality_i,
  output logic [2:0]            override_o,
  output logic [3*DelayW-1:0]   delay_o,
  output logic [2:0]            bitslip_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2:0]            fail_ch_o,
  output logic                  irq_done_o
);

  localparam int NumTaps = 2 ** DelayW;
  localparam int CntW    = $clog2(SettleCycles + DwellCycles + 1);
  localparam int SlipW   = $clog2(MaxSlips + 2);
  // Settle after a bitslip lasts one cycle longer: the pulse cycle itself.
  localparam logic [CntW-1:0]     SettleLd     = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0]     SlipSettleLd = CntW'(SettleCycles);
  localparam logic [CntW-1:0]     DwellLd      = CntW'(DwellCycles - 1);
  localparam logic [DelayW-1:0]   LastTap      = {DelayW{1'b1}};
  localparam logic [QualityW-1:0] MinQ         = QualityW'(MinQuality);
  localparam logic [SlipW-1:0]    SlipMax      = SlipW'(MaxSlips);

  typedef enum logic [2:0] {
    IDLE, SET_DELAY, DWELL, APPLY, SLIP_WAIT, SLIP_DWELL, NEXT_CH, DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [1:0]                 ch_q, ch_d;
  logic [DelayW-1:0]          tap_q, tap_d;
  logic [QualityW-1:0]        best_q_q, best_q_d;
  logic [DelayW-1:0]          best_tap_q, best_tap_d;
  logic [SlipW-1:0]           slip_q, slip_d;
  logic [2:0]                 override_q, override_d;
  logic [2:0][DelayW-1:0]     delay_q, delay_d;
  logic [2:0]                 bitslip_q, bitslip_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [2:0]                 fail_q, fail_d;
  logic                       irq_q, irq_d;
  logic [2:0][QualityW-1:0]   quality_arr;
  logic [QualityW-1:0]        q_sel;
  logic                       cnt_zero;

  assign quality_arr = quality_i;
  assign q_sel       = quality_arr[ch_q];
  assign cnt_zero    = (cnt_q == '0);

`ifdef DVI_IN_ALIGN_WINDOW_EN
  // Pass mask of the channel being calibrated; cleared when a channel starts.
  logic [NumTaps-1:0] mask_q, mask_d;
  logic [DelayW-1:0]  win_tap;
  logic               win_found;
  int                 run_len, run_first, win_len, win_first;

  // Longest run of passing taps; strict compare keeps the earliest run on ties.
  always_comb begin
    run_len   = 0;
    run_first = 0;
    win_len   = 0;
    win_first = 0;
    for (int i = 0; i < NumTaps; i++) begin
      if (mask_q[i]) begin
        if (run_len == 0) run_first = i;
        run_len = run_len + 1;
        if (run_len > win_len) begin
          win_len   = run_len;
          win_first = run_first;
        end
      end else begin
        run_len = 0;
      end
    end
    win_found = (win_len != 0);
    win_tap   = win_found ? DelayW'(win_first + (win_len - 1) / 2) : '0;
  end
`endif

  // Next-state and registered-output logic of the calibration sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_zero ? cnt_q : cnt_q - CntW'(1);
    ch_d       = ch_q;
    tap_d      = tap_q;
    best_q_d   = best_q_q;
    best_tap_d = best_tap_q;
    slip_d     = slip_q;
    override_d = override_q;
    delay_d    = delay_q;
    bitslip_d  = '0;
    busy_d     = busy_q;
    done_d     = done_q;
    fail_d     = fail_q;
    irq_d      = 1'b0;
`ifdef DVI_IN_ALIGN_WINDOW_EN
    mask_d     = mask_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = SET_DELAY;
          cnt_d      = SettleLd;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          fail_d     = '0;
          override_d = 3'b111;
          delay_d    = '0;
          ch_d       = '0;
          tap_d      = '0;
          best_q_d   = '0;
          best_tap_d = '0;
          slip_d     = '0;
`ifdef DVI_IN_ALIGN_WINDOW_EN
          mask_d     = '0;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SET_DELAY: begin
        if (cnt_zero) begin
          state_d = DWELL;
          cnt_d   = DwellLd;
        end
      end
      DWELL: begin
        if (cnt_zero) begin
          if (q_sel > best_q_q) begin
            best_q_d   = q_sel;
            best_tap_d = tap_q;
          end
`ifdef DVI_IN_ALIGN_WINDOW_EN
          mask_d[tap_q] = (q_sel >= MinQ);
`endif
          if (tap_q == LastTap) begin
            state_d = APPLY;
          end else begin
            tap_d         = tap_q + DelayW'(1);
            delay_d[ch_q] = tap_q + DelayW'(1);
            state_d       = SET_DELAY;
            cnt_d         = SettleLd;
          end
        end
      end
      APPLY: begin
`ifdef DVI_IN_ALIGN_WINDOW_EN
        delay_d[ch_q] = win_tap;
        if (!win_found) begin
`else
        delay_d[ch_q] = best_tap_q;
        if (best_q_q < MinQ) begin
`endif
          fail_d[ch_q] = 1'b1;
          state_d      = NEXT_CH;
        end else begin
          slip_d  = '0;
          state_d = SLIP_WAIT;
          cnt_d   = SettleLd;
        end
      end
      SLIP_WAIT: begin
        if (cnt_zero) begin
          state_d = SLIP_DWELL;
          cnt_d   = DwellLd;
        end
      end
      SLIP_DWELL: begin
        if (cnt_zero) begin
          if (valid_i[ch_q]) begin
            state_d = NEXT_CH;
          end else if (slip_q == SlipMax) begin
            fail_d[ch_q] = 1'b1;
            state_d      = NEXT_CH;
          end else begin
            bitslip_d[ch_q] = 1'b1;
            slip_d          = slip_q + SlipW'(1);
            state_d         = SLIP_WAIT;
            cnt_d           = SlipSettleLd;
          end
        end
      end
      NEXT_CH: begin
        if (ch_q == 2'd2) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          irq_d   = 1'b1;
        end else begin
          ch_d          = ch_q + 2'd1;
          tap_d         = '0;
          best_q_d      = '0;
          best_tap_d    = '0;
          slip_d        = '0;
          delay_d[ch_d] = '0;
          state_d       = SET_DELAY;
          cnt_d         = SettleLd;
`ifdef DVI_IN_ALIGN_WINDOW_EN
          mask_d        = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort releases the pipeline controls from any state, without an irq.
    if (abort_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      ch_d       = '0;
      tap_d      = '0;
      best_q_d   = '0;
      best_tap_d = '0;
      slip_d     = '0;
      override_d = '0;
      delay_d    = '0;
      bitslip_d  = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      fail_d     = '0;
      irq_d      = 1'b0;
`ifdef DVI_IN_ALIGN_WINDOW_EN
      mask_d     = '0;
`endif
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      tap_q      <= '0;
      best_q_q   <= '0;
      best_tap_q <= '0;
      slip_q     <= '0;
      override_q <= '0;
      delay_q    <= '0;
      bitslip_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= '0;
      irq_q      <= 1'b0;
`ifdef DVI_IN_ALIGN_WINDOW_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      tap_q      <= tap_d;
      best_q_q   <= best_q_d;
      best_tap_q <= best_tap_d;
      slip_q     <= slip_d;
      override_q <= override_d;
      delay_q    <= delay_d;
      bitslip_q  <= bitslip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      irq_q      <= irq_d;
`ifdef DVI_IN_ALIGN_WINDOW_EN
      mask_q     <= mask_d;
`endif
    end
  end

  assign override_o = override_q;
  assign delay_o    = delay_q;
  assign bitslip_o  = bitslip_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fail_ch_o  = fail_q;
  assign irq_done_o = irq_q;

endmodule

// File: tb/tb_dvi_in_align_ctrl.sv
// tb_dvi_in_align_ctrl: randomized and directed bench for dvi_in_align_ctrl.
// A channel model drives quality_i from the applied delay and raises valid_i
// after a chosen number of bitslips; a reference model predicts each result.
module tb_dvi_in_align_ctrl;
  localparam int DelayW   = 3;
  localparam int QualityW = 8;
  localparam int S        = 2;
  localparam int D        = 4;
  localparam int MaxSlips = 4;
  localparam int MinQ     = 16;
  localparam int NumTaps  = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  start_i = 1'b0;
  logic                  abort_i = 1'b0;
  logic [2:0]            valid_i;
  logic [3*QualityW-1:0] quality_i;
  logic [2:0]            override_o;
  logic [3*DelayW-1:0]   delay_o;
  logic [2:0]            bitslip_o;
  logic                  busy_o;
  logic                  done_o;
  logic [2:0]            fail_ch_o;
  logic                  irq_done_o;

  dvi_in_align_ctrl #(
    .DelayW(DelayW), .QualityW(QualityW), .SettleCycles(S), .DwellCycles(D),
    .MaxSlips(MaxSlips), .MinQuality(MinQ)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .valid_i(valid_i), .quality_i(quality_i), .override_o(override_o),
    .delay_o(delay_o), .bitslip_o(bitslip_o), .busy_o(busy_o), .done_o(done_o),
    .fail_ch_o(fail_ch_o), .irq_done_o(irq_done_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  logic [23:0] cyc = '0;
  always @(posedge clk_i) cyc <= cyc + 24'd1;

  // ---------------- environment ----------------
  logic [7:0] qtab [3][NumTaps];
  int         valid_after [3];
  int         slips_seen [3];
  int         run_id = 0;
  int         seen_run = 0;
  logic       prev_irq = 1'b0;

  always_comb begin
    quality_i = '0;
    for (int c = 0; c < 3; c++)
      quality_i[c*QualityW +: QualityW] = qtab[c][delay_o[c*DelayW +: DelayW]];
  end

  always_comb begin
    valid_i = '0;
    for (int c = 0; c < 3; c++) valid_i[c] = (slips_seen[c] >= valid_after[c]);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // {irq cycle[23:0], fail[2:0], delay ch2..ch0 [8:0], slips ch2..ch0 4b each}
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain per-channel evaluation of the tap rule, the slip
  // outcome and the cycle budget of each phase.
  function automatic logic [47:0] model(input logic [23:0] start_cyc);
    int total, tap, slips, maxv, best_len, best_first, len;
    bit ok;
    logic [2:0]  f;
    logic [8:0]  dl;
    logic [11:0] sl;
    total = 0; f = '0; dl = '0; sl = '0;
    for (int c = 0; c < 3; c++) begin
`ifdef DVI_IN_ALIGN_WINDOW_EN
      best_len = 0; best_first = 0;
      for (int s = 0; s < NumTaps; s++) begin
        len = 0;
        while (s + len < NumTaps && int'(qtab[c][s+len]) >= MinQ) len++;
        if (len > best_len) begin best_len = len; best_first = s; end
      end
      ok  = (best_len > 0);
      tap = ok ? best_first + (best_len - 1) / 2 : 0;
`else
      maxv = 0;
      for (int t = 0; t < NumTaps; t++) if (int'(qtab[c][t]) > maxv) maxv = int'(qtab[c][t]);
      tap = NumTaps;
      for (int t = NumTaps - 1; t >= 0; t--) if (int'(qtab[c][t]) == maxv) tap = t;
      ok = (maxv >= MinQ);
`endif
      total += NumTaps * (S + D) + 2;
      dl[c*3 +: 3] = 3'(tap);
      if (!ok) begin
        f[c] = 1'b1;
      end else begin
        slips = (valid_after[c] < MaxSlips) ? valid_after[c] : MaxSlips;
        if (valid_after[c] > MaxSlips) f[c] = 1'b1;
        total += (slips + 1) * (S + D) + slips;
        sl[c*4 +: 4] = 4'(slips);
      end
    end
    return {start_cyc + 24'd1 + 24'(total), f, dl, sl};
  endfunction

  // Monitor: bitslip accounting and result check on every irq pulse.
  always @(negedge clk_i) begin
    logic [47:0] e;
    if (run_id != seen_run) begin
      seen_run = run_id;
      for (int c = 0; c < 3; c++) slips_seen[c] = 0;
    end
    if (bitslip_o != 3'b000) begin
      check("bitslip_onehot", 64'($countones(bitslip_o)), 64'd1);
      for (int c = 0; c < 3; c++) if (bitslip_o[c]) slips_seen[c] = slips_seen[c] + 1;
    end
    if (irq_done_o) begin
      check("irq_single_pulse", 64'(prev_irq), 64'd0);
      if (exp_q.size() == 0) begin
        check("irq_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("irq_cycle", 64'(cyc), 64'(e[47:24]));
        check("fail_ch", 64'(fail_ch_o), 64'(e[23:21]));
        check("delay", 64'(delay_o), 64'(e[20:12]));
        check("slip_count", 64'({4'(slips_seen[2]), 4'(slips_seen[1]), 4'(slips_seen[0])}), 64'(e[11:0]));
        check("done_level", 64'(done_o), 64'd1);
        check("busy_at_done", 64'(busy_o), 64'd0);
        check("override_at_done", 64'(override_o), 64'h7);
      end
    end
    prev_irq = irq_done_o;
  end

  // ---------------- driver tasks ----------------
  task automatic set_chan(input int c, input int peak_tap, input int peak, input int base, input int va);
    for (int t = 0; t < NumTaps; t++) qtab[c][t] = 8'((t == peak_tap) ? peak : base);
    valid_after[c] = va;
  endtask

  task automatic wait_results(input string name);
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk_i);
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic pulse_start();
    run_id++;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic run_cal(input string name, input bit extra_starts);
    run_id++;
    @(negedge clk_i);
    exp_q.push_back(model(cyc));
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("start_busy", 64'(busy_o), 64'd1);
    check("start_clears_done", 64'({done_o, fail_ch_o}), 64'd0);
    check("start_override", 64'(override_o), 64'h7);
    if (extra_starts) begin
      repeat (3) begin
        repeat ($urandom_range(5, 30)) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
      end
    end
    wait_results(name);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({override_o, delay_o, bitslip_o, busy_o, done_o, fail_ch_o, irq_done_o}), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int c = 0; c < 3; c++) begin
      slips_seen[c] = 0;
      set_chan(c, 5, 40, 10, 2);
    end
    repeat (3) @(negedge clk_i);
    check_all_zero("reset_outputs");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check_all_zero("idle_outputs");

    // Peak 40 at tap 5, valid after two slips, extra starts while busy.
    run_cal("peak5", 1'b1);

    // Ch1 never reaches MinQuality.
    set_chan(1, 0, 5, 5, 2);
    run_cal("ch1_low_quality", 1'b0);

    // Ch2 valid stuck low.
    set_chan(1, 5, 40, 10, 2);
    set_chan(2, 5, 40, 10, 99);
    run_cal("ch2_valid_stuck", 1'b0);

    // Tie between taps 2 and 6.
    for (int c = 0; c < 3; c++) begin
      set_chan(c, 2, 30, 10, 1);
      qtab[c][6] = 8'd30;
    end
    run_cal("tie_2_6", 1'b0);

    // Passing taps {1,2,3,5,6}.
    for (int c = 0; c < 3; c++) begin
      for (int t = 0; t < NumTaps; t++)
        qtab[c][t] = (t == 1 || t == 2 || t == 3 || t == 5 || t == 6) ? 8'd30 : 8'd10;
      valid_after[c] = c;
    end
    run_cal("window_set", 1'b0);

    // Randomized tables and slip requirements.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 3; c++) begin
        int hi;
        hi = ($urandom_range(0, 3) == 0) ? 20 : 63;
        for (int t = 0; t < NumTaps; t++) qtab[c][t] = 8'($urandom_range(0, hi));
        valid_after[c] = $urandom_range(0, 6);
      end
      run_cal("random", r[0]);
    end

    // Abort mid-DWELL on ch1: ch0 fails quality fast, ch1 is sweeping.
    set_chan(0, 0, 5, 5, 0);
    set_chan(1, 5, 40, 10, 0);
    set_chan(2, 5, 40, 10, 0);
    pulse_start();
    repeat (59) @(negedge clk_i);
    check("busy_before_abort", 64'(busy_o), 64'd1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check_all_zero("abort_outputs");
    repeat (300) @(negedge clk_i);
    check("abort_no_restart", 64'({busy_o, done_o}), 64'd0);

    // Start and abort together while idle.
    run_id++;
    @(negedge clk_i);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    check_all_zero("start_abort_same_cycle");
    repeat (200) @(negedge clk_i);
    check("start_abort_stays_idle", 64'({busy_o, override_o}), 64'd0);

    // Reset in the middle of SLIP_WAIT on ch0.
    set_chan(0, 5, 40, 10, 3);
    pulse_start();
    repeat (49) @(negedge clk_i);
    check("override_before_reset", 64'(override_o), 64'h7);
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Normal calibration after the reset.
    run_cal("after_reset", 1'b0);

    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
